// File: rtl/data_memory_responder_pkg.sv
// Types and helpers shared by the execute-stage memory interface and its responder.
package data_memory_responder_pkg;

  localparam int WORD_BYTES = 4;

  typedef logic [3:0] byte_en_t;

  typedef struct packed {
    logic [31:0] addr;
    byte_en_t    be;
    logic [31:0] data;
  } mem_req_t;

  // Enabled lanes take new_word, the rest keep old_word.
  function automatic logic [31:0] merge_lanes(input logic [31:0] old_word,
                                              input logic [31:0] new_word,
                                              input byte_en_t    be);
    logic [31:0] merged;
    merged = old_word;
    for (int b = 0; b < WORD_BYTES; b++) begin
      if (be[b]) begin
        merged[8*b +: 8] = new_word[8*b +: 8];
      end else begin
        merged[8*b +: 8] = old_word[8*b +: 8];
      end
    end
    return merged;
  endfunction

endpackage

// File: rtl/data_memory_responder_read_pipe.sv
// DEPTH-stage valid+data shift register; data stages only load behind a valid
// so the last stage holds the previous result while idle.
module data_memory_responder_read_pipe
  import data_memory_responder_pkg::*;
#(
  parameter int DEPTH = 3,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data
);

  logic [DEPTH-1:0] valid_r;
  logic [WIDTH-1:0] data_r [DEPTH];

  // Shift valid every cycle; move data only where a valid word is arriving.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_r <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        data_r[i] <= '0;
      end
    end else begin
      valid_r[0] <= in_valid;
      if (in_valid) begin
        data_r[0] <= in_data;
      end
      for (int i = 1; i < DEPTH; i++) begin
        valid_r[i] <= valid_r[i-1];
        if (valid_r[i-1]) begin
          data_r[i] <= data_r[i-1];
        end
      end
    end
  end

  assign out_valid = valid_r[DEPTH-1];
  assign out_data  = data_r[DEPTH-1];

endmodule

// File: rtl/data_memory_responder.sv
// Word-organised RAM responder: byte-lane writes, write-first forwarding,
// fixed-latency read pipeline and out-of-range error pulse.
module data_memory_responder
  import data_memory_responder_pkg::*;
#(
  parameter int          DEPTH     = 3,
  parameter int          MEM_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        read,
  input  logic [31:0] read_address,
  input  byte_en_t    write,
  input  logic [31:0] write_address,
  input  logic [31:0] write_data,
  output logic [31:0] DATA_out,
  output logic        data_valid,
  output logic        bus_error
);

  localparam int AW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

  logic [31:0] mem_r [MEM_WORDS];

  mem_req_t    wr_req_s;
  logic        wr_en_s;
  logic        wr_ok_s;
  logic        rd_ok_s;
  logic [AW-1:0] wr_idx_s;
  logic [AW-1:0] rd_idx_s;
  logic [31:0] rd_word_s;
  logic        err_s;
  logic        bus_error_r;

  // Underflow below BASE_ADDR wraps to a huge offset, so it fails the bound too.
  function automatic logic addr_in_range(input logic [31:0] addr);
    logic [31:0] off;
    off = addr - BASE_ADDR;
    return (addr >= BASE_ADDR) && ((off / WORD_BYTES) < 32'(MEM_WORDS));
  endfunction

  function automatic logic [AW-1:0] word_index(input logic [31:0] addr);
    logic [31:0] off;
    off = addr - BASE_ADDR;
    return AW'(off / WORD_BYTES);
  endfunction

  assign wr_req_s = '{addr: write_address, be: write, data: write_data};
  assign wr_en_s  = |wr_req_s.be;
  assign wr_ok_s  = wr_en_s && addr_in_range(wr_req_s.addr);
  assign rd_ok_s  = addr_in_range(read_address);
  assign wr_idx_s = word_index(wr_req_s.addr);
  assign rd_idx_s = word_index(read_address);

  // Read word selection with write-first forwarding on a same-word collision.
  always_comb begin
    rd_word_s = 32'h0;
    if (!rd_ok_s) begin
      rd_word_s = 32'h0;
    end else if (wr_ok_s && (wr_idx_s == rd_idx_s)) begin
      rd_word_s = merge_lanes(mem_r[rd_idx_s], wr_req_s.data, wr_req_s.be);
    end else begin
      rd_word_s = mem_r[rd_idx_s];
    end
  end

  // One error pulse covers a bad read, a bad write, or both in the same cycle.
  always_comb begin
    err_s = 1'b0;
    if ((read && !rd_ok_s) || (wr_en_s && !wr_ok_s)) begin
      err_s = 1'b1;
    end else begin
      err_s = 1'b0;
    end
  end

  // RAM storage is deliberately outside reset so contents survive it.
  always_ff @(posedge clk) begin
    if (wr_ok_s) begin
      for (int b = 0; b < WORD_BYTES; b++) begin
        if (wr_req_s.be[b]) begin
          mem_r[wr_idx_s][8*b +: 8] <= wr_req_s.data[8*b +: 8];
        end
      end
    end
  end

  // Registered bus error pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus_error_r <= 1'b0;
    end else begin
      bus_error_r <= err_s;
    end
  end

  data_memory_responder_read_pipe #(
    .DEPTH (DEPTH),
    .WIDTH (32)
  ) u_read_pipe (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (read),
    .in_data   (rd_word_s),
    .out_valid (data_valid),
    .out_data  (DATA_out)
  );

  assign bus_error = bus_error_r;

endmodule

// File: tb/tb_data_memory_responder.sv
// Directed bench for data_memory_responder with hand-computed expectations (DEPTH = 3).
module tb_data_memory_responder;

  logic        clk;
  logic        reset;
  logic        read;
  logic [31:0] read_address;
  logic [3:0]  write;
  logic [31:0] write_address;
  logic [31:0] write_data;
  logic [31:0] DATA_out;
  logic        data_valid;
  logic        bus_error;

  int tests_run;
  int tests_failed;

  data_memory_responder #(
    .DEPTH     (3),
    .MEM_WORDS (1024),
    .BASE_ADDR (32'h0000_0000)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .read          (read),
    .read_address  (read_address),
    .write         (write),
    .write_address (write_address),
    .write_data    (write_data),
    .DATA_out      (DATA_out),
    .data_valid    (data_valid),
    .bus_error     (bus_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [3:0] be, input logic [31:0] data);
    write_address = addr;
    write         = be;
    write_data    = data;
    tick();
    write         = 4'b0000;
  endtask

  // Read issued at one edge; valid appears after the third edge.
  task automatic do_read(input string tag, input logic [31:0] addr,
                         input logic [31:0] exp_data, input logic exp_err);
    read_address = addr;
    read         = 1'b1;
    tick();
    read         = 1'b0;
    check({tag, "_err"}, {31'd0, bus_error}, {31'd0, exp_err});
    check({tag, "_v0"}, {31'd0, data_valid}, 32'd0);
    tick();
    check({tag, "_v1"}, {31'd0, data_valid}, 32'd0);
    check({tag, "_err_end"}, {31'd0, bus_error}, 32'd0);
    tick();
    check({tag, "_v2"}, {31'd0, data_valid}, 32'd1);
    check({tag, "_data"}, DATA_out, exp_data);
  endtask

  initial begin
    tests_run     = 0;
    tests_failed  = 0;
    reset         = 1'b0;
    read          = 1'b0;
    read_address  = 32'h0;
    write         = 4'b0000;
    write_address = 32'h0;
    write_data    = 32'h0;
    #12;
    check("rst_data", DATA_out, 32'h0);
    check("rst_valid", {31'd0, data_valid}, 32'd0);
    check("rst_err", {31'd0, bus_error}, 32'd0);
    reset = 1'b1;
    tick();

    // Full-word write then read back; DATA_out must then hold while idle.
    do_write(32'h10, 4'hF, 32'hDEADBEEF);
    do_read("full_word", 32'h10, 32'hDEADBEEF, 1'b0);
    tick();
    check("hold_valid", {31'd0, data_valid}, 32'd0);
    check("hold_data", DATA_out, 32'hDEADBEEF);
    do_read("unaligned", 32'h13, 32'hDEADBEEF, 1'b0);

    // Partial lane write.
    do_write(32'h20, 4'hF, 32'h11223344);
    do_write(32'h20, 4'b0101, 32'hAABBCCDD);
    do_read("lanes", 32'h20, 32'h11BB33DD, 1'b0);

    // Same-cycle read and write to one word: write-first forwarding.
    do_write(32'h30, 4'hF, 32'h0);
    read_address  = 32'h30;
    read          = 1'b1;
    write_address = 32'h30;
    write         = 4'b1100;
    write_data    = 32'hCAFEF00D;
    tick();
    read  = 1'b0;
    write = 4'b0000;
    tick();
    tick();
    check("fwd_valid", {31'd0, data_valid}, 32'd1);
    check("fwd_data", DATA_out, 32'hCAFE0000);
    do_read("fwd_mem", 32'h30, 32'hCAFE0000, 1'b0);

    // Back-to-back reads, then reset with one read in flight.
    do_write(32'h0, 4'hF, 32'h1);
    do_write(32'h4, 4'hF, 32'h2);
    do_write(32'h8, 4'hF, 32'h3);
    read = 1'b1;
    read_address = 32'h0; tick();
    read_address = 32'h4; tick();
    read_address = 32'h8; tick();
    check("b2b_v1", {31'd0, data_valid}, 32'd1);
    check("b2b_d1", DATA_out, 32'h1);
    read_address = 32'h0; tick();
    read = 1'b0;
    check("b2b_v2", {31'd0, data_valid}, 32'd1);
    check("b2b_d2", DATA_out, 32'h2);
    tick();
    check("b2b_v3", {31'd0, data_valid}, 32'd1);
    check("b2b_d3", DATA_out, 32'h3);
    reset = 1'b0;
    #1;
    check("mid_rst_valid", {31'd0, data_valid}, 32'd0);
    check("mid_rst_data", DATA_out, 32'h0);
    tick();
    reset = 1'b1;
    tick();
    check("post_rst_v1", {31'd0, data_valid}, 32'd0);
    tick();
    check("post_rst_v2", {31'd0, data_valid}, 32'd0);
    check("post_rst_data", DATA_out, 32'h0);

    // Out-of-range read.
    do_read("oor_read", 32'h1000, 32'h0, 1'b1);

    // Out-of-range write is dropped (must not alias onto word 0).
    do_write(32'h1000, 4'hF, 32'hFFFFFFFF);
    check("oor_wr_err", {31'd0, bus_error}, 32'd1);
    tick();
    check("oor_wr_err_end", {31'd0, bus_error}, 32'd0);
    do_read("ram_kept", 32'h0, 32'h1, 1'b0);

    // Empty byte-enable is not a write.
    do_write(32'h1000, 4'b0000, 32'h12345678);
    check("no_wr_err", {31'd0, bus_error}, 32'd0);

    // Bad read and bad write together give a single pulse.
    read_address  = 32'h2000;
    read          = 1'b1;
    write_address = 32'hFFFF_FFF0;
    write         = 4'b0001;
    write_data    = 32'h55;
    tick();
    read  = 1'b0;
    write = 4'b0000;
    check("dual_err", {31'd0, bus_error}, 32'd1);
    tick();
    check("dual_err_end", {31'd0, bus_error}, 32'd0);
    tick();
    check("dual_valid", {31'd0, data_valid}, 32'd1);
    check("dual_data", DATA_out, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
